// File: rtl/hw_accel_pkg.sv
// Shared types and helpers for the Sobel accelerator core.
package hw_accel_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int PIPE_LAT = 3;
  localparam int GRAD_W   = 11;

  // Magnitude of a two's-complement gradient; -1024 never occurs.
  function automatic logic [GRAD_W-1:0] abs_grad(input logic [GRAD_W-1:0] v);
    return v[GRAD_W-1] ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/hw_accel_line_buffer.sv
// Two cascaded line delays sharing one circular address: dly1 is the pixel
// DEPTH shifts ago, dly2 the pixel 2*DEPTH shifts ago.
module hw_accel_line_buffer #(
  parameter int DEPTH = 640,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dly1_o,
  output logic [WIDTH-1:0] dly2_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem1_q [DEPTH];
  logic [WIDTH-1:0] mem2_q [DEPTH];
  logic [AW-1:0]    addr_q, addr_d;

  assign addr_d = (addr_q == AW'(DEPTH - 1)) ? '0 : addr_q + 1'b1;
  assign dly1_o = mem1_q[addr_q];
  assign dly2_o = mem2_q[addr_q];

  always_ff @(posedge clk) begin
    if (rst) addr_q <= '0;
    else if (shift_i) addr_q <= addr_d;
  end

  // Read-before-write at the same address; contents are never cleared.
  always_ff @(posedge clk) begin
    if (shift_i) begin
      mem1_q[addr_q] <= din_i;
      mem2_q[addr_q] <= dly1_o;
    end
  end

endmodule

// File: rtl/hw_accel_sobel_core.sv
// Streaming 3x3 Sobel edge detector: one grey pixel in per beat, one binary
// edge pixel out per frame position, three register stages after the window.
module hw_accel_sobel_core
  import hw_accel_pkg::*;
#(
  parameter int DATA_WIDTH         = 32,
  parameter int FRAME_WIDTH        = 640,
  parameter int FRAME_HEIGHT       = 480,
  parameter int SOBEL_THRESH_WIDTH = 11
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [SOBEL_THRESH_WIDTH-1:0] sobel_thresh,
  input  logic [DATA_WIDTH-1:0]         pixel_in,
  input  logic                          pixel_in_valid,
  output logic [DATA_WIDTH-1:0]         pixel_out,
  output logic                          pixel_out_valid,
  output logic                          frame_done,
  output logic                          busy,
  output logic                          err_extra_input
);

  localparam int W   = FRAME_WIDTH;
  localparam int H   = FRAME_HEIGHT;
  localparam int N_W = $clog2(W * H + W + 1);
  localparam int C_W = $clog2(W);
  localparam int R_W = $clog2(H);
  localparam logic [N_W-1:0] N_LAST_IN   = N_W'(W * H - 1);
  localparam logic [N_W-1:0] N_LAST_FL   = N_W'(W * H + W);
  localparam logic [N_W-1:0] N_FIRST_OUT = N_W'(W + 1);

  state_e                        state_q, state_d;
  logic [N_W-1:0]                n_q;
  logic [SOBEL_THRESH_WIDTH-1:0] thresh_q;
  logic                          err_q, err_d;
  logic                          beat, complete;
  logic [7:0]                    beat_pix, dly1, dly2;
  logic                          unused_upper;

  assign unused_upper = ^pixel_in[DATA_WIDTH-1:8];

  // Input valid strobes are accepted unconditionally (no ready); flush beats are internal.
  always_comb begin
    state_d  = state_q;
    err_d    = err_q;
    beat     = 1'b0;
    beat_pix = pixel_in[7:0];
    case (state_q)
      IDLE: if (pixel_in_valid) begin
        beat    = 1'b1;
        state_d = RUN;
      end
      RUN: if (pixel_in_valid) begin
        beat = 1'b1;
        if (n_q == N_LAST_IN) state_d = FLUSH;
      end
      FLUSH: begin
        beat     = 1'b1;
        beat_pix = 8'h00;
        err_d    = err_q | pixel_in_valid;
        if (n_q == N_LAST_FL) state_d = DONE;
      end
      DONE:    err_d = err_q | pixel_in_valid;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      n_q      <= '0;
      thresh_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      if (beat) n_q <= n_q + 1'b1;
      if (state_q == IDLE) thresh_q <= sobel_thresh;
    end
  end

  hw_accel_line_buffer #(.DEPTH(W), .WIDTH(8)) u_line_buffer (
    .clk     (clk),
    .rst     (rst),
    .shift_i (beat),
    .din_i   (beat_pix),
    .dly1_o  (dly1),
    .dly2_o  (dly2)
  );

  logic [7:0] win_q [3][3];
  logic [7:0] win_d [3][3];
  logic [7:0] tap   [3];

  always_comb begin
    tap[0] = dly2;
    tap[1] = dly1;
    tap[2] = beat_pix;
    for (int r = 0; r < 3; r++) begin
      win_d[r][0] = win_q[r][1];
      win_d[r][1] = win_q[r][2];
      win_d[r][2] = tap[r];
    end
  end

  always_ff @(posedge clk) begin
    if (beat) win_q <= win_d;
  end

  function automatic logic [GRAD_W-1:0] ext(input logic [7:0] p);
    return GRAD_W'(p);
  endfunction

  // Stage 1 works on the window as it is being shifted in, so it lands on the beat edge.
  logic [GRAD_W-1:0] gx_d, gy_d, gx_q, gy_q, mag_q;
  assign gx_d = ext(win_d[0][2]) + (ext(win_d[1][2]) << 1) + ext(win_d[2][2])
              - ext(win_d[0][0]) - (ext(win_d[1][0]) << 1) - ext(win_d[2][0]);
  assign gy_d = ext(win_d[2][0]) + (ext(win_d[2][1]) << 1) + ext(win_d[2][2])
              - ext(win_d[0][0]) - (ext(win_d[0][1]) << 1) - ext(win_d[0][2]);

  logic [C_W-1:0]      col_q;
  logic [R_W-1:0]      row_q;
  logic                border, last;
  logic                bord1_q, bord2_q;
  logic [PIPE_LAT-1:0] vld_q, last_q;
  logic [7:0]          pix_q;

  assign complete = beat && (n_q >= N_FIRST_OUT);
  assign border   = (row_q == '0) || (row_q == R_W'(H - 1))
                 || (col_q == '0) || (col_q == C_W'(W - 1));
  assign last     = (row_q == R_W'(H - 1)) && (col_q == C_W'(W - 1));

  always_ff @(posedge clk) begin
    gx_q    <= gx_d;
    gy_q    <= gy_d;
    bord1_q <= border;
    mag_q   <= abs_grad(gx_q) + abs_grad(gy_q);
    bord2_q <= bord1_q;
    if (rst) begin
      col_q  <= '0;
      row_q  <= '0;
      vld_q  <= '0;
      last_q <= '0;
      pix_q  <= 8'h00;
    end else begin
      vld_q  <= {vld_q[PIPE_LAT-2:0], complete};
      last_q <= {last_q[PIPE_LAT-2:0], complete && last};
      pix_q  <= (vld_q[1] && !bord2_q && (mag_q >= thresh_q)) ? 8'hFF : 8'h00;
      if (complete) begin
        if (col_q == C_W'(W - 1)) begin
          col_q <= '0;
          row_q <= row_q + 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end
      end
    end
  end

  assign pixel_out       = {{(DATA_WIDTH-8){1'b0}}, pix_q};
  assign pixel_out_valid = vld_q[PIPE_LAT-1];
  assign frame_done      = vld_q[PIPE_LAT-1] & last_q[PIPE_LAT-1];
  assign busy            = (state_q == RUN) || (state_q == FLUSH);
  assign err_extra_input = err_q;

endmodule

// File: tb/tb_hw_accel_sobel_core.sv
// Self-checking bench for hw_accel_sobel_core on an 8x6 frame against an
// image-level Sobel reference model.
module tb_hw_accel_sobel_core;
  import hw_accel_pkg::*;

  localparam int W  = 8;
  localparam int H  = 6;
  localparam int N  = W * H;
  localparam int DW = 32;
  localparam int TW = 11;

  logic          clk = 1'b0;
  logic          rst;
  logic [TW-1:0] sobel_thresh;
  logic [DW-1:0] pixel_in;
  logic          pixel_in_valid;
  logic [DW-1:0] pixel_out;
  logic          pixel_out_valid, frame_done, busy, err_extra_input;

  always #5 clk = ~clk;

  hw_accel_sobel_core #(
    .DATA_WIDTH(DW), .FRAME_WIDTH(W), .FRAME_HEIGHT(H), .SOBEL_THRESH_WIDTH(TW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .sobel_thresh    (sobel_thresh),
    .pixel_in        (pixel_in),
    .pixel_in_valid  (pixel_in_valid),
    .pixel_out       (pixel_out),
    .pixel_out_valid (pixel_out_valid),
    .frame_done      (frame_done),
    .busy            (busy),
    .err_extra_input (err_extra_input)
  );

  int            img [H][W];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] act_val [$];
  int            act_cyc [$];
  logic          act_done [$];
  int            beat_cyc [N];
  int            cyc = 0;
  int            cmps = 0;
  int            fails = 0;
  int            stray_done = 0;
  int            busy_fall = -1;
  logic          busy_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Output capture, sampled mid-cycle.
  always @(negedge clk) begin
    if (pixel_out_valid) begin
      act_val.push_back(pixel_out);
      act_cyc.push_back(cyc);
      act_done.push_back(frame_done);
    end else if (frame_done) begin
      stray_done++;
    end
    if (busy_prev && !busy) busy_fall = cyc;
    busy_prev = busy;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  task automatic build_expected(input int thr);
    int r, c, gx, gy, mag;
    exp_q.delete();
    for (int k = 0; k < N; k++) begin
      r = k / W;
      c = k % W;
      if (r == 0 || r == H - 1 || c == 0 || c == W - 1) begin
        exp_q.push_back(32'h0);
      end else begin
        gx = (img[r-1][c+1] + 2 * img[r][c+1] + img[r+1][c+1])
           - (img[r-1][c-1] + 2 * img[r][c-1] + img[r+1][c-1]);
        gy = (img[r+1][c-1] + 2 * img[r+1][c] + img[r+1][c+1])
           - (img[r-1][c-1] + 2 * img[r-1][c] + img[r-1][c+1]);
        mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        exp_q.push_back(mag >= thr ? 32'hFF : 32'h0);
      end
    end
  endtask

  // Cycle in which window-completing beat n occurs; flush beats follow the last input.
  function automatic int beat_cycle(input int n);
    return (n < N) ? beat_cyc[n] : beat_cyc[N-1] + 1 + (n - N);
  endfunction

  task automatic fill_step(input int lo, input int hi);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) img[r][c] = (c < W / 2) ? lo : hi;
  endtask

  task automatic fill_random();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) img[r][c] = int'($urandom_range(0, 255));
  endtask

  // ---------------- drivers ----------------
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    pixel_in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    act_val.delete();
    act_cyc.delete();
    act_done.delete();
    stray_done = 0;
    busy_fall = -1;
  endtask

  task automatic drive_frame(input int nbeats, input int max_gap, input int thr_mid,
                             input bit extra_flush);
    int gap;
    for (int n = 0; n < nbeats; n++) begin
      gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      repeat (gap) begin
        @(negedge clk);
        pixel_in_valid = 1'b0;
      end
      @(negedge clk);
      if (n == N / 2 && thr_mid >= 0) sobel_thresh = TW'(thr_mid);
      pixel_in_valid = 1'b1;
      pixel_in = {24'($urandom), 8'(img[n / W][n % W])};
      beat_cyc[n] = cyc;
    end
    if (nbeats == N) begin
      @(negedge clk);
      pixel_in_valid = extra_flush;
      pixel_in = $urandom;
      @(negedge clk);
      pixel_in_valid = 1'b0;
      repeat (W + PIPE_LAT + 8) @(negedge clk);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    pixel_in_valid = 1'b0;
    repeat (3) @(negedge clk);
    cmps++; if (pixel_out !== 32'h0) begin fails++; $display("FAIL reset_pixel_out: got %h expected 0", pixel_out); end
    cmps++; if (pixel_out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", pixel_out_valid); end
    cmps++; if (frame_done !== 1'b0) begin fails++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
    cmps++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
    cmps++; if (err_extra_input !== 1'b0) begin fails++; $display("FAIL reset_err: got %b expected 0", err_extra_input); end
    cmps++; if (dut.state_q !== IDLE) begin fails++; $display("FAIL reset_state: got %0d expected IDLE", dut.state_q); end
  endtask

  task automatic test_constant();
    do_reset();
    fill_step(50, 50);
    sobel_thresh = 11'd100;
    build_expected(100);
    drive_frame(N, 0, -1, 1'b0);
    cmps++; if (act_val.size() !== N) begin fails++; $display("FAIL const_count: got %0d expected %0d", act_val.size(), N); end
    if (act_cyc.size() > 0) begin
      cmps++; if (act_cyc[0] !== beat_cyc[W+1] + PIPE_LAT) begin fails++; $display("FAIL const_first_latency: got cycle %0d expected %0d", act_cyc[0], beat_cyc[W+1] + PIPE_LAT); end
    end
    for (int k = 0; k < act_val.size() && k < N; k++) begin
      cmps++; if (act_val[k] !== exp_q[k]) begin fails++; $display("FAIL const_pixel[%0d]: got %h expected %h", k, act_val[k], exp_q[k]); end
      cmps++; if (act_cyc[k] !== beat_cycle(k + W + 1) + PIPE_LAT) begin fails++; $display("FAIL const_timing[%0d]: got cycle %0d expected %0d", k, act_cyc[k], beat_cycle(k + W + 1) + PIPE_LAT); end
      cmps++; if (act_done[k] !== (k == N - 1)) begin fails++; $display("FAIL const_frame_done[%0d]: got %b expected %b", k, act_done[k], k == N - 1); end
    end
    cmps++; if (stray_done !== 0) begin fails++; $display("FAIL const_stray_done: got %0d expected 0", stray_done); end
    cmps++; if (busy_fall !== beat_cyc[N-1] + W + 2) begin fails++; $display("FAIL const_busy_fall: got cycle %0d expected %0d", busy_fall, beat_cyc[N-1] + W + 2); end
    cmps++; if (err_extra_input !== 1'b0) begin fails++; $display("FAIL const_err: got %b expected 0", err_extra_input); end
  endtask

  task automatic test_vertical_step();
    do_reset();
    fill_step(0, 200);
    sobel_thresh = 11'd100;
    build_expected(100);
    drive_frame(N, 0, -1, 1'b0);
    cmps++; if (act_val.size() !== N) begin fails++; $display("FAIL vstep_count: got %0d expected %0d", act_val.size(), N); end
    for (int k = 0; k < act_val.size() && k < N; k++) begin
      cmps++; if (act_val[k] !== exp_q[k]) begin fails++; $display("FAIL vstep_pixel[%0d]: got %h expected %h", k, act_val[k], exp_q[k]); end
    end
  endtask

  task automatic test_threshold();
    do_reset();
    fill_step(0, 25);
    sobel_thresh = 11'd100;
    build_expected(100);
    drive_frame(N, 0, 101, 1'b0);
    cmps++; if (act_val.size() !== N) begin fails++; $display("FAIL thr100_count: got %0d expected %0d", act_val.size(), N); end
    for (int k = 0; k < act_val.size() && k < N; k++) begin
      cmps++; if (act_val[k] !== exp_q[k]) begin fails++; $display("FAIL thr100_pixel[%0d]: got %h expected %h", k, act_val[k], exp_q[k]); end
    end
    do_reset();
    build_expected(101);
    drive_frame(N, 0, -1, 1'b0);
    cmps++; if (act_val.size() !== N) begin fails++; $display("FAIL thr101_count: got %0d expected %0d", act_val.size(), N); end
    for (int k = 0; k < act_val.size() && k < N; k++) begin
      cmps++; if (act_val[k] !== exp_q[k]) begin fails++; $display("FAIL thr101_pixel[%0d]: got %h expected %h", k, act_val[k], exp_q[k]); end
    end
  endtask

  task automatic test_gaps();
    int thr;
    do_reset();
    fill_random();
    thr = int'($urandom_range(150, 700));
    sobel_thresh = TW'(thr);
    build_expected(thr);
    drive_frame(N, 3, -1, 1'b0);
    cmps++; if (act_val.size() !== N) begin fails++; $display("FAIL gaps_count: got %0d expected %0d", act_val.size(), N); end
    for (int k = 0; k < act_val.size() && k < N; k++) begin
      cmps++; if (act_val[k] !== exp_q[k]) begin fails++; $display("FAIL gaps_pixel[%0d]: got %h expected %h", k, act_val[k], exp_q[k]); end
      cmps++; if (act_cyc[k] !== beat_cycle(k + W + 1) + PIPE_LAT) begin fails++; $display("FAIL gaps_timing[%0d]: got cycle %0d expected %0d", k, act_cyc[k], beat_cycle(k + W + 1) + PIPE_LAT); end
    end
  endtask

  task automatic test_extra_input();
    do_reset();
    fill_step(0, 200);
    sobel_thresh = 11'd100;
    build_expected(100);
    drive_frame(N, 0, -1, 1'b1);
    @(negedge clk);
    pixel_in_valid = 1'b1;
    pixel_in = $urandom;
    @(negedge clk);
    pixel_in_valid = 1'b0;
    repeat (6) @(negedge clk);
    cmps++; if (act_val.size() !== N) begin fails++; $display("FAIL extra_count: got %0d expected %0d", act_val.size(), N); end
    for (int k = 0; k < act_val.size() && k < N; k++) begin
      cmps++; if (act_val[k] !== exp_q[k]) begin fails++; $display("FAIL extra_pixel[%0d]: got %h expected %h", k, act_val[k], exp_q[k]); end
    end
    cmps++; if (err_extra_input !== 1'b1) begin fails++; $display("FAIL extra_err: got %b expected 1", err_extra_input); end
    cmps++; if (busy !== 1'b0) begin fails++; $display("FAIL extra_busy: got %b expected 0", busy); end
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    fill_step(0, 200);
    sobel_thresh = 11'd100;
    drive_frame(20, 0, -1, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    pixel_in_valid = 1'b1;
    pixel_in = {24'h0, 8'(img[20 / W][20 % W])};
    @(negedge clk);
    cmps++; if (pixel_out_valid !== 1'b0) begin fails++; $display("FAIL midrst_valid: got %b expected 0", pixel_out_valid); end
    cmps++; if (pixel_out !== 32'h0) begin fails++; $display("FAIL midrst_pixel_out: got %h expected 0", pixel_out); end
    cmps++; if (busy !== 1'b0) begin fails++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    cmps++; if (frame_done !== 1'b0) begin fails++; $display("FAIL midrst_frame_done: got %b expected 0", frame_done); end
    cmps++; if (dut.state_q !== IDLE) begin fails++; $display("FAIL midrst_state: got %0d expected IDLE", dut.state_q); end
    rst = 1'b0;
    pixel_in_valid = 1'b0;
    act_val.delete();
    act_cyc.delete();
    act_done.delete();
    repeat (10) @(negedge clk);
    cmps++; if (act_val.size() !== 0) begin fails++; $display("FAIL midrst_no_output: got %0d outputs expected 0", act_val.size()); end
    build_expected(100);
    drive_frame(N, 0, -1, 1'b0);
    cmps++; if (act_val.size() !== N) begin fails++; $display("FAIL midrst_frame_count: got %0d expected %0d", act_val.size(), N); end
    for (int k = 0; k < act_val.size() && k < N; k++) begin
      cmps++; if (act_val[k] !== exp_q[k]) begin fails++; $display("FAIL midrst_pixel[%0d]: got %h expected %h", k, act_val[k], exp_q[k]); end
    end
  endtask

  initial begin
    rst = 1'b1;
    pixel_in_valid = 1'b0;
    pixel_in = '0;
    sobel_thresh = 11'd100;
    test_reset();
    test_constant();
    test_vertical_step();
    test_threshold();
    test_gaps();
    test_extra_input();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, fails);
    $finish;
  end

endmodule
